// File: rtl/alu_mem_skid_stage_if.sv
// Handshake and payload bundle between the ALU stage, the ALU->memory skid register and the memory stage.
// The slave view belongs to the stage register and the master view to whoever drives and consumes it.
interface alu_mem_skid_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int MEM_CTRL_WIDTH = 7,
    parameter int WB_CTRL_WIDTH  = 2
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [DATA_WIDTH-1:0]     base_reg_content_load_post;
    logic [DATA_WIDTH-1:0]     mem_data_write;
    logic [REG_ADDR_WIDTH-1:0] wb_address;
    logic [REG_ADDR_WIDTH-1:0] base_register_address;
    logic [MEM_CTRL_WIDTH-1:0] mem_control;
    logic [WB_CTRL_WIDTH-1:0]  wb_control;

    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WIDTH-1:0]     alu_result_out;
    logic [DATA_WIDTH-1:0]     base_reg_content_out;
    logic [DATA_WIDTH-1:0]     mem_data_write_out;
    logic [REG_ADDR_WIDTH-1:0] wb_address_out;
    logic [REG_ADDR_WIDTH-1:0] base_register_address_out;
    logic [MEM_CTRL_WIDTH-1:0] mem_control_out;
    logic [WB_CTRL_WIDTH-1:0]  wb_control_out;

    modport slave (
        input  in_valid, alu_result, base_reg_content_load_post, mem_data_write,
               wb_address, base_register_address, mem_control, wb_control,
        output in_ready,
        output out_valid, alu_result_out, base_reg_content_out, mem_data_write_out,
               wb_address_out, base_register_address_out, mem_control_out, wb_control_out,
        input  out_ready
    );

    modport master (
        output in_valid, alu_result, base_reg_content_load_post, mem_data_write,
               wb_address, base_register_address, mem_control, wb_control,
        input  in_ready,
        input  out_valid, alu_result_out, base_reg_content_out, mem_data_write_out,
               wb_address_out, base_register_address_out, mem_control_out, wb_control_out,
        output out_ready
    );
endinterface

// File: rtl/alu_mem_skid_stage.sv
// ALU->memory pipeline register with valid/ready handshake and a two-entry skid buffer.
// in_ready depends only on registered state, so there is no combinational path from out_ready.
module alu_mem_skid_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int MEM_CTRL_WIDTH = 7,
    parameter int WB_CTRL_WIDTH  = 2,
    parameter int WB_EN_BIT      = 0
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      flush,
    alu_mem_skid_stage_if.slave       bus,
    output logic                      fwd_valid,
    output logic [REG_ADDR_WIDTH-1:0] fwd_address,
    output logic [DATA_WIDTH-1:0]     fwd_data,
    output logic [1:0]                occupancy
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     alu_result;
        logic [DATA_WIDTH-1:0]     base_reg_content;
        logic [DATA_WIDTH-1:0]     mem_data_write;
        logic [REG_ADDR_WIDTH-1:0] wb_address;
        logic [REG_ADDR_WIDTH-1:0] base_register_address;
        logic [MEM_CTRL_WIDTH-1:0] mem_control;
        logic [WB_CTRL_WIDTH-1:0]  wb_control;
    } payload_t;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t   r_state;
    state_t   w_next_state;
    payload_t r_head;
    payload_t r_skid;
    payload_t w_in_payload;
    logic     w_in_ready;
    logic     w_out_valid;
    logic     w_accept;
    logic     w_emit;
    logic     w_load_head_in;
    logic     w_load_skid_in;
    logic     w_head_from_skid;

    assign w_in_payload.alu_result            = bus.alu_result;
    assign w_in_payload.base_reg_content      = bus.base_reg_content_load_post;
    assign w_in_payload.mem_data_write        = bus.mem_data_write;
    assign w_in_payload.wb_address            = bus.wb_address;
    assign w_in_payload.base_register_address = bus.base_register_address;
    assign w_in_payload.mem_control           = bus.mem_control;
    assign w_in_payload.wb_control            = bus.wb_control;

    assign w_in_ready  = (r_state != TWO);
    assign w_out_valid = (r_state != EMPTY);
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_emit      = w_out_valid & bus.out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Flush wins over everything and suppresses loading the offered entry, so it can never surface.
    always_comb begin
        w_next_state     = r_state;
        w_load_head_in   = 1'b0;
        w_load_skid_in   = 1'b0;
        w_head_from_skid = 1'b0;
        if (flush) begin
            w_next_state = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_load_head_in = 1'b1;
                        w_next_state   = ONE;
                    end
                end
                ONE: begin
                    if (w_accept && w_emit) begin
                        w_load_head_in = 1'b1;
                    end else if (w_accept) begin
                        w_load_skid_in = 1'b1;
                        w_next_state   = TWO;
                    end else if (w_emit) begin
                        w_next_state = EMPTY;
                    end
                end
                TWO: begin
                    if (w_emit) begin
                        w_head_from_skid = 1'b1;
                        w_next_state     = ONE;
                    end
                end
                default: begin
                    w_next_state = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_head_in) begin
                r_head <= w_in_payload;
            end else if (w_head_from_skid) begin
                r_head <= r_skid;
            end
            if (w_load_skid_in) begin
                r_skid <= w_in_payload;
            end
        end
    end

    // Control words read as NOP during bubbles so downstream never acts on stale head contents.
    assign bus.in_ready                  = w_in_ready;
    assign bus.out_valid                 = w_out_valid;
    assign bus.alu_result_out            = r_head.alu_result;
    assign bus.base_reg_content_out      = r_head.base_reg_content;
    assign bus.mem_data_write_out        = r_head.mem_data_write;
    assign bus.wb_address_out            = r_head.wb_address;
    assign bus.base_register_address_out = r_head.base_register_address;
    assign bus.mem_control_out           = w_out_valid ? r_head.mem_control : '0;
    assign bus.wb_control_out            = w_out_valid ? r_head.wb_control  : '0;

    assign fwd_valid   = w_out_valid & r_head.wb_control[WB_EN_BIT];
    assign fwd_address = r_head.wb_address;
    assign fwd_data    = r_head.alu_result;
    assign occupancy   = r_state;

endmodule

// File: tb/tb_alu_mem_skid_stage.sv
// Directed bench for alu_mem_skid_stage; a queue model of the held entries predicts every output.
module tb_alu_mem_skid_stage;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int MW = 7;
    localparam int WW = 2;

    typedef struct packed {
        logic [DW-1:0] alu;
        logic [DW-1:0] base;
        logic [DW-1:0] mdata;
        logic [AW-1:0] wbaddr;
        logic [AW-1:0] baddr;
        logic [MW-1:0] memctl;
        logic [WW-1:0] wbctl;
    } entry_t;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush   = 1'b0;
    logic          fwd_valid;
    logic [AW-1:0] fwd_address;
    logic [DW-1:0] fwd_data;
    logic [1:0]    occupancy;

    alu_mem_skid_stage_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW),
                            .MEM_CTRL_WIDTH(MW), .WB_CTRL_WIDTH(WW)) bus ();

    alu_mem_skid_stage #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .MEM_CTRL_WIDTH(MW),
        .WB_CTRL_WIDTH(WW), .WB_EN_BIT(0)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .bus        (bus),
        .fwd_valid  (fwd_valid),
        .fwd_address(fwd_address),
        .fwd_data   (fwd_data),
        .occupancy  (occupancy)
    );

    always #5 clock = ~clock;

    entry_t scoreboard[$];
    entry_t lastHead = '0;
    entry_t curEntry = '0;
    int     total    = 0;
    int     bad      = 0;

    function automatic entry_t makeEntry(input logic [DW-1:0] alu, input logic [AW-1:0] wa,
                                         input logic [WW-1:0] wc, input logic [MW-1:0] mc);
        entry_t e;
        e.alu    = alu;
        e.base   = alu ^ 32'hFFFF_0000;
        e.mdata  = alu + 32'd1;
        e.wbaddr = wa;
        e.baddr  = wa + 4'd1;
        e.memctl = mc;
        e.wbctl  = wc;
        return e;
    endfunction

    task automatic checkValue(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input entry_t e, input logic ordy, input logic fl);
        curEntry                       = e;
        bus.in_valid                   = valid;
        bus.alu_result                 = e.alu;
        bus.base_reg_content_load_post = e.base;
        bus.mem_data_write             = e.mdata;
        bus.wb_address                 = e.wbaddr;
        bus.base_register_address      = e.baddr;
        bus.mem_control                = e.memctl;
        bus.wb_control                 = e.wbctl;
        bus.out_ready                  = ordy;
        flush                          = fl;
    endtask

    // During a bubble the data outputs must still show the last entry that sat at the head.
    task automatic checkOutput();
        bit     expValid;
        entry_t head;
        expValid = (scoreboard.size() != 0);
        if (expValid) lastHead = scoreboard[0];
        head = lastHead;
        checkValue("out_valid", DW'(bus.out_valid), DW'(expValid));
        checkValue("in_ready", DW'(bus.in_ready), DW'(scoreboard.size() != 2));
        checkValue("occupancy", DW'(occupancy), DW'(scoreboard.size()));
        checkValue("alu_result_out", bus.alu_result_out, head.alu);
        checkValue("base_reg_content_out", bus.base_reg_content_out, head.base);
        checkValue("mem_data_write_out", bus.mem_data_write_out, head.mdata);
        checkValue("wb_address_out", DW'(bus.wb_address_out), DW'(head.wbaddr));
        checkValue("base_register_address_out", DW'(bus.base_register_address_out), DW'(head.baddr));
        checkValue("mem_control_out", DW'(bus.mem_control_out), expValid ? DW'(head.memctl) : '0);
        checkValue("wb_control_out", DW'(bus.wb_control_out), expValid ? DW'(head.wbctl) : '0);
        checkValue("fwd_valid", DW'(fwd_valid), DW'(expValid && head.wbctl[0]));
        checkValue("fwd_address", DW'(fwd_address), DW'(head.wbaddr));
        checkValue("fwd_data", fwd_data, head.alu);
    endtask

    task automatic tick();
        bit accept;
        bit emit;
        @(negedge clock);
        checkOutput();
        accept = reset_n && bus.in_valid && (scoreboard.size() != 2) && !flush;
        emit   = reset_n && (scoreboard.size() != 0) && bus.out_ready;
        @(posedge clock);
        if (emit) void'(scoreboard.pop_front());
        if (flush) scoreboard.delete();
        else if (accept) scoreboard.push_back(curEntry);
        #1;
    endtask

    task automatic drain();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4 && scoreboard.size() != 0; i++) tick();
        tick();
    endtask

    initial begin
        applyStimulus(1'b0, '0, 1'b0, 1'b0);

        $display("[TB] reset and idle");
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();

        $display("[TB] passthrough");
        applyStimulus(1'b1, makeEntry(32'h11, 4'd1, 2'b01, 7'h11), 1'b1, 1'b0); tick();
        applyStimulus(1'b1, makeEntry(32'h22, 4'd2, 2'b00, 7'h22), 1'b1, 1'b0); tick();
        applyStimulus(1'b1, makeEntry(32'h33, 4'd3, 2'b11, 7'h33), 1'b1, 1'b0); tick();
        drain();

        $display("[TB] backpressure");
        applyStimulus(1'b1, makeEntry(32'hA0, 4'd10, 2'b01, 7'h5A), 1'b0, 1'b0); tick();
        applyStimulus(1'b1, makeEntry(32'hB0, 4'd11, 2'b10, 7'h2B), 1'b0, 1'b0); tick();
        applyStimulus(1'b1, makeEntry(32'hC0, 4'd12, 2'b01, 7'h4C), 1'b0, 1'b0); tick();
        bus.out_ready = 1'b1; tick();
        tick();
        drain();

        $display("[TB] flush");
        applyStimulus(1'b1, makeEntry(32'hA1, 4'd6, 2'b01, 7'h61), 1'b0, 1'b0); tick();
        applyStimulus(1'b1, makeEntry(32'hB1, 4'd7, 2'b01, 7'h71), 1'b0, 1'b0); tick();
        applyStimulus(1'b1, makeEntry(32'hDD, 4'd13, 2'b01, 7'h7F), 1'b0, 1'b1); tick();
        applyStimulus(1'b0, makeEntry(32'hDD, 4'd13, 2'b01, 7'h7F), 1'b1, 1'b0); tick();
        tick();

        $display("[TB] forwarding");
        applyStimulus(1'b1, makeEntry(32'h1234, 4'd5, 2'b01, 7'h01), 1'b0, 1'b0); tick();
        bus.in_valid = 1'b0; tick();
        drain();
        applyStimulus(1'b1, makeEntry(32'h1234, 4'd5, 2'b00, 7'h01), 1'b0, 1'b0); tick();
        bus.in_valid = 1'b0; tick();
        drain();

        $display("[TB] accept and emit with out_ready toggling");
        applyStimulus(1'b1, makeEntry(32'hE1, 4'd1, 2'b01, 7'h0E), 1'b0, 1'b0); tick();
        applyStimulus(1'b1, makeEntry(32'hE2, 4'd2, 2'b01, 7'h1E), 1'b1, 1'b0); tick();
        applyStimulus(1'b1, makeEntry(32'hE3, 4'd3, 2'b00, 7'h2E), 1'b0, 1'b0); tick();
        applyStimulus(1'b1, makeEntry(32'hE4, 4'd4, 2'b01, 7'h3E), 1'b1, 1'b0); tick();
        drain();

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, makeEntry(32'hF1, 4'd8, 2'b01, 7'h51), 1'b0, 1'b0); tick();
        applyStimulus(1'b1, makeEntry(32'hF2, 4'd9, 2'b01, 7'h52), 1'b0, 1'b0); tick();
        applyStimulus(1'b1, makeEntry(32'hF3, 4'd4, 2'b01, 7'h53), 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        scoreboard.delete();
        lastHead = '0;
        checkOutput();
        tick();
        reset_n = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
